seq_detector_param: RTL

- Parametrised serial bit-pattern detector. It is the successor to the fixed 101010 detector.
- Pattern width is a parameter. The pattern can be reloaded at run time.
- Overlapping and non-overlapping match modes are supported.
- Input samples are qualified by a valid strobe, and a saturating match counter is provided.
- Sits on a serial bit stream, e.g. a frame-sync or preamble search ahead of a deserialiser.

---
 rtl/seq_detector_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector: run-time reloadable pattern, overlap control,
// valid-qualified input and saturating match counter. Define SEQDET_MASK_EN to add mask_in.
module seq_detector_param #(
  parameter int               PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = 6'b101010,
  parameter int               CNT_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   x_valid,
  input  logic                   x,
  input  logic                   overlap_en,
  input  logic                   load_pat,
  input  logic [PAT_W-1:0]       pat_in,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0]       mask_in,
`endif
  output logic                   z,
  output logic [CNT_W-1:0]       match_count,
  output logic [$clog2(PAT_W):0] fill
);

  localparam int                FILL_W   = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

  // Only the newest PAT_W-1 bits are ever needed to build the next compare window.
  logic [PAT_W-2:0]  r_hist;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  w_nxt;
  logic              w_match;
  logic              w_hit;
  logic [PAT_W-2:0]  w_hist_nxt;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_z_nxt;

  assign w_nxt = {r_hist, x};

`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] r_mask;
  logic [PAT_W-1:0] w_mask_nxt;

  assign w_match = (((w_nxt ^ r_pat) & r_mask) == {PAT_W{1'b0}});

  // Mask follows the pattern register: cleared to all-ones, reloaded on load_pat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mask <= {PAT_W{1'b1}};
    end else begin
      r_mask <= w_mask_nxt;
    end
  end

  // Next mask value.
  always_comb begin
    w_mask_nxt = r_mask;
    if (load_pat) begin
      w_mask_nxt = mask_in;
    end else begin
      w_mask_nxt = r_mask;
    end
  end
`else
  assign w_match = (w_nxt == r_pat);
`endif

  assign w_hit = (fill >= FILL_ARM) && w_match;

  // Next-state for history, pattern, fill, counter and match pulse; load beats sample.
  always_comb begin
    w_hist_nxt = r_hist;
    w_pat_nxt  = r_pat;
    w_fill_nxt = fill;
    w_cnt_nxt  = match_count;
    w_z_nxt    = 1'b0;
    if (load_pat) begin
      w_pat_nxt  = pat_in;
      w_hist_nxt = {(PAT_W-1){1'b0}};
      w_fill_nxt = {FILL_W{1'b0}};
    end else if (x_valid) begin
      w_hist_nxt = w_nxt[PAT_W-2:0];
      w_z_nxt    = w_hit;
      if (w_hit && (match_count != CNT_SAT)) begin
        w_cnt_nxt = match_count + CNT_W'(1);
      end else begin
        w_cnt_nxt = match_count;
      end
      // A non-overlapping hit demands PAT_W fresh bits before the next match.
      if (w_hit && !overlap_en) begin
        w_fill_nxt = {FILL_W{1'b0}};
      end else if (fill != FILL_MAX) begin
        w_fill_nxt = fill + FILL_W'(1);
      end else begin
        w_fill_nxt = fill;
      end
    end else begin
      w_z_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist      <= {(PAT_W-1){1'b0}};
      r_pat       <= PATTERN;
      fill        <= {FILL_W{1'b0}};
      match_count <= {CNT_W{1'b0}};
      z           <= 1'b0;
    end else begin
      r_hist      <= w_hist_nxt;
      r_pat       <= w_pat_nxt;
      fill        <= w_fill_nxt;
      match_count <= w_cnt_nxt;
      z           <= w_z_nxt;
    end
  end

endmodule
